// File: rtl/fft_frame_sequencer_if.sv
// ----------------------------------------------------------------------------
// fft_frame_sequencer_if
// Control bundle between the FFT frame sequencer and the blocks it drives:
// SPI frame buffer, sample feeder, FFT core, output buffer and MCU handshake.
//
// Modports
//   master : the sequencer. Samples the status levels and beats, and drives
//            the control strobes and status outputs.
//   slave  : the surrounding datapath and MCU side (the mirror image).
//
// Signals
//   fft_loaded     SPI holds a full frame (level, already synced to clk)
//   fft_load       feeder hands a sample to the FFT core this cycle
//   fft_processing FFT core busy
//   out_buf_ready  output buffer holds the complete result
//   mcu_ack        MCU finished reading the result (level)
//   feed_go        1-cycle pulse: feeder latches the frame and starts sending
//   fft_start      1-cycle pulse: all samples delivered, start the transform
//   out_clear      1-cycle pulse: clear the output-buffer word count
//   result_ready   level: result valid for MCU readout
//   busy           sequencer is not idle
//   state_dbg      current sequencer state
//   frame_cnt      completed frames, wraps
//   overrun        sticky: frame arrived while not idle
//   timeout_err    sticky: watchdog expired
// ----------------------------------------------------------------------------
interface fft_frame_sequencer_if #(
    parameter int FCNT_W = 16
);
    logic              fft_loaded;
    logic              fft_load;
    logic              fft_processing;
    logic              out_buf_ready;
    logic              mcu_ack;
    logic              feed_go;
    logic              fft_start;
    logic              out_clear;
    logic              result_ready;
    logic              busy;
    logic [2:0]        state_dbg;
    logic [FCNT_W-1:0] frame_cnt;
    logic              overrun;
    logic              timeout_err;

    modport master (
        input  fft_loaded, fft_load, fft_processing, out_buf_ready, mcu_ack,
        output feed_go, fft_start, out_clear, result_ready, busy,
               state_dbg, frame_cnt, overrun, timeout_err
    );

    modport slave (
        output fft_loaded, fft_load, fft_processing, out_buf_ready, mcu_ack,
        input  feed_go, fft_start, out_clear, result_ready, busy,
               state_dbg, frame_cnt, overrun, timeout_err
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// ----------------------------------------------------------------------------
// fft_frame_sequencer
// Frame controller for the MCU<->FPGA FFT path. One frame runs:
//   SPI frame arrives -> feeder streams N_SAMPLES into the FFT core ->
//   fft_start -> output buffer fills -> result flagged to MCU -> MCU ack.
// Also owns the watchdog, overrun detection and the completed-frame counter.
//
// Ports
//   clk    system clock
//   reset  synchronous, active-high; aborts any frame with no strobes
//   bus    fft_frame_sequencer_if.master (status in, strobes/status out)
// ----------------------------------------------------------------------------
module fft_frame_sequencer #(
    parameter int N_SAMPLES = 512,
    parameter int TIMEOUT   = 65535,
    parameter int TO_W      = 16,
    parameter int FCNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    fft_frame_sequencer_if.master        bus
);
    localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_START   = 3'd2,
        S_COMPUTE = 3'd3,
        S_READY   = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t             r_state, w_next;
    logic               r_loaded_prev;
    logic [CNT_W-1:0]   r_count;
    logic [TO_W-1:0]    r_wd;
    logic [FCNT_W-1:0]  r_frame_cnt;
    logic               r_overrun;
    logic               r_timeout_err;
    logic               r_result_ready;

    logic w_trigger, w_take, w_wd_expired, w_last_beat;
    logic w_feed_go, w_fft_start, w_busy;

    assign w_trigger    = bus.fft_loaded & ~r_loaded_prev;
    assign w_take       = w_trigger & ~bus.fft_processing;
    // Expiring at TIMEOUT-1 means FEED/COMPUTE last exactly TIMEOUT cycles.
    assign w_wd_expired = (r_wd == TO_W'(TIMEOUT - 1));
    assign w_last_beat  = bus.fft_load && (r_count == CNT_W'(N_SAMPLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state; watchdog beats the normal exit in FEED and COMPUTE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_take) w_next = S_FEED;
            S_FEED: begin
                if (w_wd_expired)     w_next = S_ERROR;
                else if (w_last_beat) w_next = S_START;
            end
            S_START:   w_next = S_COMPUTE;
            S_COMPUTE: begin
                if (w_wd_expired)          w_next = S_ERROR;
                else if (bus.out_buf_ready) w_next = S_READY;
            end
            S_READY:   if (bus.mcu_ack) w_next = S_IDLE;
            S_ERROR:   w_next = S_ERROR;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs; strobes are suppressed while reset is asserted
    always_comb begin
        w_feed_go   = 1'b0;
        w_fft_start = 1'b0;
        w_busy      = (r_state != S_IDLE);
        if (!reset) begin
            case (r_state)
                S_IDLE:  w_feed_go   = w_take;
                S_START: w_fft_start = 1'b1;
                default: ;
            endcase
        end
    end

    // Sample counter, watchdog, sticky flags and frame counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_loaded_prev  <= 1'b0;
            r_count        <= '0;
            r_wd           <= '0;
            r_frame_cnt    <= '0;
            r_overrun      <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_result_ready <= 1'b0;
        end else begin
            r_loaded_prev <= bus.fft_loaded;

            // Beats outside FEED are not counted
            if (r_state != S_FEED)  r_count <= '0;
            else if (w_last_beat)   r_count <= '0;
            else if (bus.fft_load)  r_count <= r_count + 1'b1;

            if (w_next != r_state)
                r_wd <= '0;
            else if (r_state == S_FEED || r_state == S_COMPUTE)
                r_wd <= r_wd + 1'b1;

            // A new frame while busy is dropped, only flagged
            if (w_trigger && r_state != S_IDLE) r_overrun <= 1'b1;

            if (r_state == S_READY && bus.mcu_ack) r_frame_cnt <= r_frame_cnt + 1'b1;

            r_result_ready <= (w_next == S_READY);
            if (w_next == S_ERROR) r_timeout_err <= 1'b1;
        end
    end

    assign bus.feed_go      = w_feed_go;
    assign bus.out_clear    = w_feed_go;
    assign bus.fft_start    = w_fft_start;
    assign bus.busy         = w_busy;
    assign bus.result_ready = r_result_ready;
    assign bus.state_dbg    = r_state;
    assign bus.frame_cnt    = r_frame_cnt;
    assign bus.overrun      = r_overrun;
    assign bus.timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer.
// dut_a: full-size (512 samples, 16-bit watchdog) for nominal / gapped frames.
// dut_b: small (8 samples, TIMEOUT=100, 2-bit frame counter) for the vector
//        table, watchdog, reset and wrap cases, and a random run against a model.
module tb_fft_frame_sequencer;
    localparam int BN = 8;
    localparam int BT = 100;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_cmp = 0, n_bad = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_frame_sequencer_if #(.FCNT_W(16)) ifa ();
    fft_frame_sequencer_if #(.FCNT_W(2))  ifb ();

    fft_frame_sequencer #(.N_SAMPLES(512), .TIMEOUT(65535), .TO_W(16), .FCNT_W(16))
        dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    fft_frame_sequencer #(.N_SAMPLES(BN), .TIMEOUT(BT), .TO_W(8), .FCNT_W(2))
        dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    // Strobe monitors
    int a_go = 0, a_clr = 0, a_start = 0, a_start_cyc = -1, a_load_cyc = -1;
    int b_go = 0, b_start = 0;
    always @(negedge clk) begin
        if (ifa.feed_go)   a_go++;
        if (ifa.out_clear) a_clr++;
        if (ifa.fft_start) begin a_start++; a_start_cyc = cyc; end
        if (ifa.fft_load)  a_load_cyc = cyc;
        if (ifb.feed_go)   b_go++;
        if (ifb.fft_start) b_start++;
    end

    typedef struct {
        int rst, ld, fl, proc, obr, ack, n;
        int st, go, strt, rr, ovr, fc;
    } vec_t;
    vec_t tv[26];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic drv_a(input bit ld, fl, proc, obr, ack);
        ifa.fft_loaded = ld; ifa.fft_load = fl; ifa.fft_processing = proc;
        ifa.out_buf_ready = obr; ifa.mcu_ack = ack;
    endtask

    task automatic drv_b(input bit rst, ld, fl, proc, obr, ack);
        rst_b = rst;
        ifb.fft_loaded = ld; ifb.fft_load = fl; ifb.fft_processing = proc;
        ifb.out_buf_ready = obr; ifb.mcu_ack = ack;
    endtask

    task automatic b_frame();
        drv_b(0, 0, 0, 0, 0, 0); tick();
        drv_b(0, 1, 0, 0, 0, 0); tick();
        drv_b(0, 1, 1, 0, 0, 0); tick(BN);
        drv_b(0, 1, 0, 0, 0, 0); tick(2);
        drv_b(0, 1, 0, 0, 1, 0); tick();
        drv_b(0, 1, 0, 0, 0, 1); tick();
        drv_b(0, 1, 0, 0, 0, 0);
    endtask

    // Reference model state for dut_b (phase numbers are the documented state codes)
    int m_ph, m_beats, m_age, m_fc, nph;
    bit m_prev, m_ovr;
    bit r_rst, r_ld, r_fl, r_proc, r_obr, r_ack, trig, e_go, e_st;
    int g0, s0, act, exp;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        tv = '{
            '{1,0,0,0,0,0,2, 0,0,0,0,0,0},
            '{0,0,0,0,0,0,1, 0,0,0,0,0,0},
            '{0,1,0,0,0,0,1, 0,1,0,0,0,0},
            '{0,1,1,0,0,0,7, 1,0,0,0,0,0},
            '{0,1,1,0,0,0,1, 1,0,0,0,0,0},
            '{0,1,0,0,0,0,1, 2,0,1,0,0,0},
            '{0,1,0,0,0,0,1, 3,0,0,0,0,0},
            '{0,1,0,0,1,0,1, 3,0,0,0,0,0},
            '{0,1,0,0,0,0,1, 4,0,0,1,0,0},
            '{0,1,0,0,0,1,1, 4,0,0,1,0,0},
            '{0,1,0,0,0,1,3, 0,0,0,0,0,1},
            '{0,0,0,0,0,0,1, 0,0,0,0,0,1},
            '{0,1,0,1,0,0,1, 0,0,0,0,0,1},
            '{0,1,0,0,0,0,2, 0,0,0,0,0,1},
            '{0,0,0,0,0,0,1, 0,0,0,0,0,1},
            '{0,1,0,0,0,0,1, 0,1,0,0,0,1},
            '{0,0,1,0,0,0,1, 1,0,0,0,0,1},
            '{0,1,1,0,0,0,1, 1,0,0,0,0,1},
            '{0,1,1,0,0,0,6, 1,0,0,0,1,1},
            '{0,1,0,0,0,0,1, 2,0,1,0,1,1},
            '{0,1,0,0,0,0,1, 3,0,0,0,1,1},
            '{0,0,0,0,0,0,1, 3,0,0,0,1,1},
            '{0,1,0,0,0,0,1, 3,0,0,0,1,1},
            '{0,1,0,0,1,0,1, 3,0,0,0,1,1},
            '{0,1,0,0,0,1,1, 4,0,0,1,1,1},
            '{0,1,0,0,0,0,1, 0,0,0,0,1,2}
        };
        rst_a = 1'b1;
        drv_a(0, 0, 0, 0, 0);
        drv_b(1, 0, 0, 0, 0, 0);
        tick(2);

        // ---- dut_a: reset values
        rst_a = 1'b0;
        smp();
        chk("a_rst_state", int'(ifa.state_dbg), 0);
        chk("a_rst_cnt", int'(ifa.frame_cnt), 0);
        chk("a_rst_flags", int'({ifa.feed_go, ifa.fft_start, ifa.out_clear, ifa.result_ready,
                                 ifa.busy, ifa.overrun, ifa.timeout_err}), 0);
        tick();

        // ---- dut_a: nominal frame with an overrun during COMPUTE
        drv_a(1, 0, 0, 0, 0);
        smp();
        chk("a_go_clr_pulse", int'({ifa.feed_go, ifa.out_clear}), 3);
        tick();
        drv_a(1, 1, 0, 0, 0); tick(512);
        drv_a(1, 0, 0, 0, 0);
        smp();
        chk("a_start_pulse", int'(ifa.fft_start), 1);
        chk("a_start_latency", a_start_cyc - a_load_cyc, 1);
        tick();
        drv_a(0, 0, 1, 0, 0); tick();
        drv_a(1, 0, 1, 0, 0); tick(98);
        smp();
        chk("a_compute_state", int'(ifa.state_dbg), 3);
        chk("a_overrun", int'(ifa.overrun), 1);
        tick();
        drv_a(1, 0, 0, 1, 0); tick();
        drv_a(1, 0, 0, 0, 0);
        smp();
        chk("a_ready", int'({ifa.state_dbg, ifa.result_ready}), 9);
        tick();
        drv_a(1, 0, 0, 0, 1); tick();
        drv_a(1, 0, 0, 0, 0);
        smp();
        chk("a_done_state", int'({ifa.state_dbg, ifa.result_ready, ifa.busy}), 0);
        chk("a_frame_cnt1", int'(ifa.frame_cnt), 1);
        chk("a_pulse_counts", a_go * 100 + a_clr * 10 + a_start, 111);
        tick();

        // ---- dut_a: gapped feed, stall at 511, then the 512th beat
        drv_a(0, 0, 0, 0, 0); tick();
        drv_a(1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 511; i++) begin
            drv_a(1, 1, 0, 0, 0); tick();
            drv_a(1, 0, 0, 0, 0); tick();
        end
        tick(20);
        smp();
        chk("a_stall_state", int'(ifa.state_dbg), 1);
        chk("a_stall_no_start", a_start, 1);
        tick();
        drv_a(1, 1, 0, 0, 0); tick();
        drv_a(1, 0, 0, 0, 0);
        smp();
        chk("a_gap_start", int'(ifa.fft_start), 1);
        chk("a_gap_latency", a_start_cyc - a_load_cyc, 1);
        tick();
        drv_a(1, 0, 0, 1, 0); tick();
        drv_a(1, 0, 0, 0, 1); tick();
        drv_a(1, 0, 0, 0, 0); tick();
        smp();
        chk("a_frame_cnt2", int'(ifa.frame_cnt), 2);
        chk("a_go_total", a_go, 2);
        tick();

        // ---- dut_b: vector table
        for (int i = 0; i < 26; i++) begin
            drv_b(tv[i].rst[0], tv[i].ld[0], tv[i].fl[0], tv[i].proc[0], tv[i].obr[0], tv[i].ack[0]);
            tick(tv[i].n - 1);
            smp();
            exp = (tv[i].st << 6) | (tv[i].go << 5) | (tv[i].strt << 4) |
                  (tv[i].rr << 3) | (tv[i].ovr << 2) | tv[i].fc;
            act = int'({ifb.state_dbg, ifb.feed_go, ifb.fft_start, ifb.result_ready,
                        ifb.overrun, ifb.frame_cnt});
            chk($sformatf("vec%0d", i), act, exp);
            tick();
        end

        // ---- dut_b: watchdog in FEED after 5 of 8 beats
        drv_b(1, 0, 0, 0, 0, 0); tick();
        drv_b(0, 0, 0, 0, 0, 0); tick();
        drv_b(0, 1, 0, 0, 0, 0); tick();
        drv_b(0, 1, 1, 0, 0, 0); tick(5);
        drv_b(0, 1, 0, 0, 0, 0); tick(BT - 6);
        smp();
        chk("wd_last_feed_cycle", int'({ifb.state_dbg, ifb.timeout_err}), 2);
        tick();
        smp();
        chk("wd_error", int'({ifb.state_dbg, ifb.timeout_err}), 11);
        tick();
        g0 = b_go; s0 = b_start;
        for (int i = 0; i < 10; i++) begin
            drv_b(0, 0, 1, 0, 1, 1); tick();
            drv_b(0, 1, 1, 0, 1, 1); tick();
        end
        smp();
        chk("wd_terminal", int'({ifb.state_dbg, ifb.timeout_err, ifb.overrun}), 23);
        chk("wd_no_strobes", (b_go - g0) + (b_start - s0), 0);
        tick();

        // ---- dut_b: reset mid-COMPUTE, then 2 and 5 frames (2-bit counter wraps)
        drv_b(1, 0, 0, 0, 0, 0); tick();
        drv_b(0, 0, 0, 0, 0, 0); tick();
        drv_b(0, 1, 0, 0, 0, 0); tick();
        drv_b(0, 1, 1, 0, 0, 0); tick(BN);
        drv_b(0, 1, 0, 0, 0, 0); tick(3);
        smp();
        chk("pre_rst_compute", int'(ifb.state_dbg), 3);
        tick();
        drv_b(1, 0, 0, 0, 0, 0); tick();
        drv_b(0, 0, 0, 0, 0, 0);
        smp();
        chk("rst_mid_compute", int'({ifb.state_dbg, ifb.feed_go, ifb.fft_start, ifb.result_ready,
                                     ifb.busy, ifb.overrun, ifb.timeout_err, ifb.frame_cnt}), 0);
        tick();
        s0 = b_start;
        b_frame(); b_frame();
        smp();
        chk("two_frames", int'({ifb.state_dbg, ifb.overrun, ifb.frame_cnt}), 2);
        tick();
        b_frame(); b_frame(); b_frame();
        smp();
        chk("five_frames_wrap", int'(ifb.frame_cnt), 1);
        chk("five_starts", b_start - s0, 5);
        tick();

        // ---- dut_b: random stimulus against the reference model
        drv_b(1, 0, 0, 0, 0, 0); tick();
        m_ph = 0; m_beats = 0; m_age = 0; m_fc = 0; m_prev = 0; m_ovr = 0;
        r_ld = 0;
        for (int k = 0; k < 3000; k++) begin
            r_rst  = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 11) == 0) r_ld = !r_ld;
            r_fl   = $urandom_range(0, 1) != 0;
            r_proc = ($urandom_range(0, 7) == 0);
            r_obr  = ($urandom_range(0, 29) == 0);
            r_ack  = ($urandom_range(0, 9) == 0);
            drv_b(r_rst, r_ld, r_fl, r_proc, r_obr, r_ack);
            @(negedge clk);
            trig = r_ld && !m_prev;
            e_go = !r_rst && m_ph == 0 && trig && !r_proc;
            e_st = !r_rst && m_ph == 2;
            exp = (m_ph << 9) | (int'(e_go) << 8) | (int'(e_st) << 7) | (int'(e_go) << 6) |
                  (int'(m_ph == 4) << 5) | (int'(m_ph != 0) << 4) | (int'(m_ovr) << 3) |
                  (int'(m_ph == 5) << 2) | m_fc;
            act = int'({ifb.state_dbg, ifb.feed_go, ifb.fft_start, ifb.out_clear,
                        ifb.result_ready, ifb.busy, ifb.overrun, ifb.timeout_err, ifb.frame_cnt});
            chk($sformatf("rand%0d", k), act, exp);
            if (r_rst) begin
                m_ph = 0; m_beats = 0; m_age = 0; m_fc = 0; m_prev = 0; m_ovr = 0;
            end else begin
                nph = m_ph;
                if (trig && m_ph != 0) m_ovr = 1;
                case (m_ph)
                    0: if (e_go) nph = 1;
                    1: begin
                        if (r_fl) m_beats++;
                        if (m_age == BT - 1)     nph = 5;
                        else if (m_beats == BN)  nph = 2;
                    end
                    2: nph = 3;
                    3: if (m_age == BT - 1) nph = 5; else if (r_obr) nph = 4;
                    4: if (r_ack) begin nph = 0; m_fc = (m_fc + 1) % 4; end
                    default: ;
                endcase
                if (nph != m_ph) begin m_age = 0; m_beats = 0; end
                else m_age++;
                m_ph = nph;
                m_prev = r_ld;
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
